mem_port_master: RTL and testbench

Initiator for the data port of the processor's unified word memory. It accepts load, store and clear requests from the datapath over a valid/ready handshake and drives the memory's second-operation controls: enable, 2-bit op code, word address and write data. Read data is captured from the memory's combinational output and returned over a valid/ready response channel. It sits between the calculator datapath and the memory's data port; the instruction-fetch path is untouched.

---
 rtl/mem_port_pkg.sv | 54 +++++
 rtl/mem_port_master_if.sv | 47 ++++
 rtl/mem_port_master.sv | 188 ++++++++++++++++++
 tb/tb_mem_port_master.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_pkg.sv
// ---------------------------------------------------------------------------
// mem_port_pkg
// Shared definitions for the data-port initiator of the unified word memory:
// op encodings (shared by the request channel and the memory op code), the
// initiator FSM state type, memory geometry constants and the burst-count
// helper used when a request is accepted.
// ---------------------------------------------------------------------------
package mem_port_pkg;

    // Request / memory op encoding.
    typedef enum logic [1:0] {
        OP_CLEAR   = 2'b00,
        OP_ILLEGAL = 2'b01,
        OP_READ    = 2'b10,
        OP_WRITE   = 2'b11
    } mem_op_e;

    // Initiator FSM states.
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        DRIVE = 2'b01,
        RESP  = 2'b10
    } state_e;

    // Data words sit above the first DATA_OFFSET words of the array.
    localparam int unsigned DATA_OFFSET = 100;
    localparam int unsigned MEM_WORDS   = 1024;
    localparam int unsigned DATA_WORDS  = MEM_WORDS - DATA_OFFSET;

    // Width of the burst length field and of the internal word counter.
    localparam int unsigned LEN_W = 5;

    // Number of words a request touches: reads and writes always move one
    // word; a clear moves req_len words, with 0 promoted to 1 and anything
    // above max_burst cut down to max_burst.
    function automatic logic [LEN_W-1:0] burst_count(
        input logic [1:0]       op,
        input logic [LEN_W-1:0] len,
        input logic [LEN_W-1:0] max_burst
    );
        logic [LEN_W-1:0] cnt;
        if ((op == OP_READ) || (op == OP_WRITE)) begin
            cnt = 5'd1;
        end else if (len == 5'd0) begin
            cnt = 5'd1;
        end else if (len > max_burst) begin
            cnt = max_burst;
        end else begin
            cnt = len;
        end
        return cnt;
    endfunction

endpackage

// File: rtl/mem_port_master_if.sv
// ---------------------------------------------------------------------------
// mem_port_master_if
// Bundles the three channels of the data-port initiator:
//   request  : req_valid/req_ready handshake with op, addr, wdata, len
//   response : resp_valid/resp_ready handshake with rdata and err
//   memory   : mem_en, mem_rw, mem_addr, mem_wdata out; mem_rdata back
// master modport = the initiator; slave modport = datapath + memory side.
// ---------------------------------------------------------------------------
interface mem_port_master_if;

    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [4:0]  req_len;

    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;

    logic        mem_en;
    logic [1:0]  mem_rw;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    modport master (
        input  req_valid, req_op, req_addr, req_wdata, req_len,
        input  resp_ready,
        input  mem_rdata,
        output req_ready,
        output resp_valid, resp_rdata, resp_err,
        output mem_en, mem_rw, mem_addr, mem_wdata
    );

    modport slave (
        output req_valid, req_op, req_addr, req_wdata, req_len,
        output resp_ready,
        output mem_rdata,
        input  req_ready,
        input  resp_valid, resp_rdata, resp_err,
        input  mem_en, mem_rw, mem_addr, mem_wdata
    );

endinterface

// File: rtl/mem_port_master.sv
// ---------------------------------------------------------------------------
// mem_port_master
// Initiator for the data port of the unified word memory. Accepts one
// load/store/clear request at a time, drives the memory's second-operation
// controls from registers and returns a single response per request.
//
// Ports:
//   clk   - rising-edge clock
//   rst_n - synchronous active-low reset
//   bus   - mem_port_master_if.master (request, response, memory channels)
//
// Parameters:
//   DATA_WORDS - addressable data words (range check limit)
//   MAX_BURST  - largest clear burst
// ---------------------------------------------------------------------------
module mem_port_master #(
    parameter int unsigned DATA_WORDS = mem_port_pkg::DATA_WORDS,
    parameter int unsigned MAX_BURST  = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    mem_port_master_if.master  bus
);

    import mem_port_pkg::*;

    localparam logic [LEN_W-1:0] MAX_BURST_C  = LEN_W'(MAX_BURST);
    localparam logic [32:0]      DATA_WORDS_C = 33'(DATA_WORDS);

    state_e           state_q,      state_d;
    logic [1:0]       op_q,         op_d;
    logic [LEN_W-1:0] cnt_q,        cnt_d;
    logic             req_ready_q,  req_ready_d;
    logic             resp_valid_q, resp_valid_d;
    logic             resp_err_q,   resp_err_d;
    logic [31:0]      resp_rdata_q, resp_rdata_d;
    logic             mem_en_q,     mem_en_d;
    logic [1:0]       mem_rw_q,     mem_rw_d;
    logic [31:0]      mem_addr_q,   mem_addr_d;
    logic [31:0]      mem_wdata_q,  mem_wdata_d;

    logic             req_ready_s;
    logic             req_hs_s;
    logic             resp_hs_s;
    logic [LEN_W-1:0] req_cnt_s;
    logic [32:0]      last_addr_s;
    logic             req_illegal_s;

    // Request handshake and legality of the word range the request touches.
    always_comb begin
        // Ready is masked by reset so nothing is taken while rst_n is low.
        req_ready_s = req_ready_q & rst_n;
        req_hs_s    = bus.req_valid & req_ready_s;
        resp_hs_s   = resp_valid_q & bus.resp_ready;
        req_cnt_s   = burst_count(bus.req_op, bus.req_len, MAX_BURST_C);
        // 33-bit sum: a range that wraps past 2^32 lands above the limit.
        last_addr_s = {1'b0, bus.req_addr} + {28'd0, req_cnt_s} - 33'd1;
        req_illegal_s = (bus.req_op == OP_ILLEGAL) || (last_addr_s >= DATA_WORDS_C);
    end

    // Next-state and next-output logic of the request/drive/response FSM.
    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        cnt_d        = cnt_q;
        req_ready_d  = req_ready_q;
        resp_valid_d = resp_valid_q;
        resp_err_d   = resp_err_q;
        resp_rdata_d = resp_rdata_q;
        mem_en_d     = mem_en_q;
        mem_rw_d     = mem_rw_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;

        case (state_q)
            IDLE: begin
                if (req_hs_s) begin
                    op_d        = bus.req_op;
                    cnt_d       = req_cnt_s;
                    req_ready_d = 1'b0;
                    if (req_illegal_s) begin
                        // Rejected: the memory bus stays idle.
                        state_d      = RESP;
                        resp_err_d   = 1'b1;
                        resp_rdata_d = 32'd0;
                    end else begin
                        state_d    = DRIVE;
                        mem_en_d   = 1'b1;
                        mem_rw_d   = bus.req_op;
                        mem_addr_d = bus.req_addr;
                        if (bus.req_op == OP_WRITE) begin
                            mem_wdata_d = bus.req_wdata;
                        end else begin
                            mem_wdata_d = 32'd0;
                        end
                    end
                end else begin
                    req_ready_d = 1'b1;
                end
            end

            DRIVE: begin
                // The word addressed this cycle is read back combinationally.
                if (op_q == OP_READ) begin
                    resp_rdata_d = bus.mem_rdata;
                end else begin
                    resp_rdata_d = 32'd0;
                end
                if (cnt_q <= 5'd1) begin
                    state_d     = RESP;
                    cnt_d       = 5'd0;
                    mem_en_d    = 1'b0;
                    mem_rw_d    = OP_READ;
                    mem_wdata_d = 32'd0;
                end else begin
                    cnt_d      = cnt_q - 5'd1;
                    mem_addr_d = mem_addr_q + 32'd1;
                end
            end

            RESP: begin
                // resp_valid rises one cycle after entering RESP and holds
                // until the consumer takes it.
                if (resp_hs_s) begin
                    state_d      = IDLE;
                    resp_valid_d = 1'b0;
                    resp_err_d   = 1'b0;
                    resp_rdata_d = 32'd0;
                    req_ready_d  = 1'b1;
                end else begin
                    resp_valid_d = 1'b1;
                end
            end

            default: begin
                state_d      = IDLE;
                cnt_d        = 5'd0;
                req_ready_d  = 1'b0;
                resp_valid_d = 1'b0;
                resp_err_d   = 1'b0;
                resp_rdata_d = 32'd0;
                mem_en_d     = 1'b0;
                mem_rw_d     = OP_READ;
                mem_addr_d   = 32'd0;
                mem_wdata_d  = 32'd0;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            op_q         <= OP_READ;
            cnt_q        <= 5'd0;
            req_ready_q  <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= 32'd0;
            mem_en_q     <= 1'b0;
            mem_rw_q     <= OP_READ;
            mem_addr_q   <= 32'd0;
            mem_wdata_q  <= 32'd0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            cnt_q        <= cnt_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            resp_rdata_q <= resp_rdata_d;
            mem_en_q     <= mem_en_d;
            mem_rw_q     <= mem_rw_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
        end
    end

    assign bus.req_ready  = req_ready_s;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_err   = resp_err_q;
    assign bus.resp_rdata = resp_rdata_q;
    assign bus.mem_en     = mem_en_q;
    assign bus.mem_rw     = mem_rw_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_mem_port_master.sv
// ---------------------------------------------------------------------------
// tb_mem_port_master
// Drives mem_port_master with directed and random requests. A word memory
// with combinational read sits on the memory channel; an array of expected
// data words plus per-request rules (latency, error, access list) form the
// reference.
// ---------------------------------------------------------------------------
module tb_mem_port_master;

    localparam int DW = 924;
    localparam int MB = 16;

    typedef struct {
        int          edge_no;
        logic [1:0]  rw;
        logic [31:0] addr;
        logic [31:0] wdata;
    } acc_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   edge_cnt = 0;
    int   n_vec = 0;
    int   n_err = 0;
    logic mem_wipe = 1'b1;

    logic [31:0] mem_arr [0:1023];
    logic [31:0] ref_mem [0:DW-1];
    logic [9:0]  mem_idx;
    acc_t        log_q [$];

    mem_port_master_if ifc ();

    mem_port_master #(.DATA_WORDS(DW), .MAX_BURST(MB)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // Memory model: +100 offset, combinational read, write/clear on the edge.
    assign mem_idx = ifc.mem_addr[9:0] + 10'd100;
    assign ifc.mem_rdata = mem_arr[mem_idx];

    always @(posedge clk) begin
        if (mem_wipe) begin
            for (int i = 0; i < 1024; i++) mem_arr[i] <= 32'd0;
        end else if (ifc.mem_en) begin
            if (ifc.mem_rw == 2'b11) mem_arr[mem_idx] <= ifc.mem_wdata;
            else if (ifc.mem_rw == 2'b00) mem_arr[mem_idx] <= 32'd0;
            log_q.push_back('{edge_cnt + 1, ifc.mem_rw, ifc.mem_addr, ifc.mem_wdata});
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present a request and wait (bounded) for its acceptance edge.
    task automatic issue_req(input logic [1:0] op, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [4:0] len,
                             output int e0, output bit ok);
        ok = 1'b0;
        e0 = 0;
        ifc.req_valid = 1'b1;
        ifc.req_op    = op;
        ifc.req_addr  = addr;
        ifc.req_wdata = wdata;
        ifc.req_len   = len;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (ifc.req_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        chk("req_accepted", 64'(ok), 64'd1);
        if (ok) begin
            @(posedge clk);
            #1;
            e0 = edge_cnt;
        end
        ifc.req_valid = 1'b0;
        ifc.req_wdata = $urandom;
    endtask

    // One full transaction checked against the rule-based model.
    task automatic run_txn(input logic [1:0] op, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [4:0] len,
                           input int hold);
        int          n;
        int          e0;
        int          lat;
        int          exp_acc;
        bit          ok;
        logic        exp_err;
        logic [31:0] exp_rdata;
        logic [63:0] end_addr;

        n = int'(len);
        if (op == 2'b10 || op == 2'b11) n = 1;
        if (n == 0) n = 1;
        if (n > MB) n = MB;
        end_addr  = {32'd0, addr} + 64'(n);
        exp_err   = (op == 2'b01) || (end_addr > 64'(DW));
        exp_rdata = 32'd0;
        if (!exp_err && op == 2'b10) exp_rdata = ref_mem[addr[9:0]];
        exp_acc   = exp_err ? 0 : n;

        log_q.delete();
        issue_req(op, addr, wdata, len, e0, ok);
        if (!ok) return;

        lat = 0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (ifc.resp_valid === 1'b1) begin
                lat = k;
                break;
            end
        end
        chk("resp_latency", 64'(lat), 64'(exp_err ? 1 : n + 1));
        chk("resp_err", 64'(ifc.resp_err), 64'(exp_err));
        chk("resp_rdata", 64'(ifc.resp_rdata), 64'(exp_rdata));

        // Back-pressure: response held, a competing request is refused.
        if (hold > 0) begin
            ifc.req_valid = 1'b1;
            ifc.req_op    = 2'b11;
            ifc.req_addr  = 32'd0;
            for (int h = 0; h < hold; h++) begin
                @(posedge clk);
                #1;
                chk("hold_resp_valid", 64'(ifc.resp_valid), 64'd1);
                chk("hold_resp_rdata", 64'(ifc.resp_rdata), 64'(exp_rdata));
                chk("hold_resp_err", 64'(ifc.resp_err), 64'(exp_err));
                chk("hold_req_ready", 64'(ifc.req_ready), 64'd0);
            end
            ifc.req_valid = 1'b0;
        end

        chk("access_count", 64'(log_q.size()), 64'(exp_acc));
        for (int i = 0; i < exp_acc && i < log_q.size(); i++) begin
            chk("access_edge", 64'(log_q[i].edge_no), 64'(e0 + 1 + i));
            chk("access_rw", 64'(log_q[i].rw), 64'(op));
            chk("access_addr", 64'(log_q[i].addr), 64'(addr + 32'(i)));
            chk("access_wdata", 64'(log_q[i].wdata), 64'(op == 2'b11 ? wdata : 32'd0));
        end

        ifc.resp_ready = 1'b1;
        @(posedge clk);
        #1;
        ifc.resp_ready = 1'b0;
        chk("post_resp_valid", 64'(ifc.resp_valid), 64'd0);
        chk("post_resp_err", 64'(ifc.resp_err), 64'd0);
        chk("post_resp_rdata", 64'(ifc.resp_rdata), 64'd0);
        chk("post_req_ready", 64'(ifc.req_ready), 64'd1);

        if (!exp_err) begin
            for (int i = 0; i < n; i++) begin
                if (op == 2'b11) ref_mem[addr[9:0] + 10'(i)] = wdata;
                else if (op == 2'b00) ref_mem[addr[9:0] + 10'(i)] = 32'd0;
            end
        end
    endtask

    initial begin
        int  e0;
        bit  ok;
        int  r;
        logic [31:0] a;

        for (int i = 0; i < DW; i++) ref_mem[i] = 32'd0;
        ifc.req_valid  = 1'b0;
        ifc.req_op     = 2'b10;
        ifc.req_addr   = 32'd0;
        ifc.req_wdata  = 32'd0;
        ifc.req_len    = 5'd0;
        ifc.resp_ready = 1'b0;

        // Reset values.
        repeat (3) @(posedge clk);
        #1;
        mem_wipe = 1'b0;
        chk("rst_req_ready", 64'(ifc.req_ready), 64'd0);
        chk("rst_resp_valid", 64'(ifc.resp_valid), 64'd0);
        chk("rst_resp_err", 64'(ifc.resp_err), 64'd0);
        chk("rst_resp_rdata", 64'(ifc.resp_rdata), 64'd0);
        chk("rst_mem_en", 64'(ifc.mem_en), 64'd0);
        chk("rst_mem_rw", 64'(ifc.mem_rw), 64'd2);
        chk("rst_mem_addr", 64'(ifc.mem_addr), 64'd0);
        chk("rst_mem_wdata", 64'(ifc.mem_wdata), 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rel_req_ready", 64'(ifc.req_ready), 64'd1);

        // Write then read back with a held response.
        run_txn(2'b11, 32'd5, 32'hDEADBEEF, 5'd0, 0);
        run_txn(2'b10, 32'd5, 32'd0, 5'd0, 3);

        // Clear burst over previously written words; neighbour untouched.
        for (int i = 10; i < 14; i++) run_txn(2'b11, 32'(i), 32'h1111, 5'd0, 0);
        run_txn(2'b11, 32'd14, 32'h2222, 5'd0, 0);
        run_txn(2'b00, 32'd10, 32'd0, 5'd4, 0);
        for (int i = 10; i < 15; i++) run_txn(2'b10, 32'(i), 32'd0, 5'd0, 0);

        // Illegal op and range boundaries.
        run_txn(2'b01, 32'd0, 32'd0, 5'd0, 0);
        run_txn(2'b11, 32'd923, 32'h0BADF00D, 5'd0, 0);
        run_txn(2'b00, 32'd923, 32'd0, 5'd2, 0);
        run_txn(2'b10, 32'd923, 32'd0, 5'd0, 0);
        run_txn(2'b00, 32'hFFFFFFFF, 32'd0, 5'd2, 0);
        run_txn(2'b10, 32'd924, 32'd0, 5'd0, 0);
        run_txn(2'b00, 32'd908, 32'd0, 5'd31, 0);
        run_txn(2'b00, 32'd907, 32'd0, 5'd31, 1);
        run_txn(2'b00, 32'd5, 32'd0, 5'd0, 0);
        run_txn(2'b10, 32'd5, 32'd0, 5'd0, 0);

        // Reset during the second word of an 8-word clear.
        for (int i = 0; i < 8; i++) run_txn(2'b11, 32'(i), 32'hA0 + 32'(i), 5'd0, 0);
        log_q.delete();
        issue_req(2'b00, 32'd0, 32'd0, 5'd8, e0, ok);
        if (ok) begin
            @(posedge clk);
            #1;
            rst_n = 1'b0;
            @(posedge clk);
            #1;
            chk("midrst_mem_en", 64'(ifc.mem_en), 64'd0);
            chk("midrst_resp_valid", 64'(ifc.resp_valid), 64'd0);
            chk("midrst_req_ready", 64'(ifc.req_ready), 64'd0);
            chk("midrst_mem_rw", 64'(ifc.mem_rw), 64'd2);
            chk("midrst_mem_addr", 64'(ifc.mem_addr), 64'd0);
            chk("midrst_accesses", 64'(log_q.size()), 64'd2);
            rst_n = 1'b1;
            @(posedge clk);
            #1;
            chk("midrst_rel_ready", 64'(ifc.req_ready), 64'd1);
            repeat (2) @(posedge clk);
            #1;
            chk("midrst_no_resp", 64'(ifc.resp_valid), 64'd0);
            ref_mem[0] = 32'd0;
            ref_mem[1] = 32'd0;
        end
        for (int i = 0; i < 8; i++) run_txn(2'b10, 32'(i), 32'd0, 5'd0, 0);

        // Random traffic against the model.
        for (int t = 0; t < 60; t++) begin
            r = $urandom_range(0, 9);
            if (r == 0) a = $urandom;
            else if (r == 1) a = 32'd900 + 32'($urandom_range(0, 30));
            else a = 32'($urandom_range(0, 60));
            run_txn(2'($urandom_range(0, 3)), a, $urandom, 5'($urandom_range(0, 31)),
                    $urandom_range(0, 2));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
